// File: rtl/interrupt_control_logic.sv
// 8259-style interrupt control: IRR/ISR, rotating priority, two-pulse INTA handshake, OCW2 EOI.
// Optional: define AUTO_ROTATE_EN to enable rotate-in-AEOI mode (OCW2 commands 100/000).
module interrupt_control_logic #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] RESET_LP    = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] IR,
  input  logic       INTA_n,
  input  logic [7:0] IMR,
  input  logic       LTIM,
  input  logic       EOI_mode,
  input  logic [4:0] VEC_ADD,
  input  logic [2:0] EOI_command,
  input  logic [2:0] int_level,
  input  logic       EOI_command_updated,
  input  logic       read_mode,
  output logic       INT,
  output logic       int_flag,
  output logic [7:0] vector,
  output logic [7:0] rd_data,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  typedef enum logic [2:0] {IDLE, WAIT1, ACK1, WAIT2, ACK2} state_t;
  state_t state, state_nxt;

  logic [7:0]             ir_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] inta_sync, tog_sync;
  logic [7:0]             ir_s, ir_d;
  logic                   inta_s, inta_d, tog_s, tog_d;
  logic                   inta_fall, inta_rise;

  // Reset values describe an idle bus: no requests, INTA released.
  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) ir_sync[i] <= '0;
      inta_sync <= '1;
      tog_sync  <= '0;
      ir_d      <= '0;
      inta_d    <= 1'b1;
      tog_d     <= 1'b0;
    end else begin
      ir_sync[0]   <= IR;
      inta_sync[0] <= INTA_n;
      tog_sync[0]  <= EOI_command_updated;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ir_sync[i]   <= ir_sync[i-1];
        inta_sync[i] <= inta_sync[i-1];
        tog_sync[i]  <= tog_sync[i-1];
      end
      ir_d   <= ir_s;
      inta_d <= inta_s;
      tog_d  <= tog_s;
    end
  end

  assign ir_s      = ir_sync[SYNC_STAGES-1];
  assign inta_s    = inta_sync[SYNC_STAGES-1];
  assign tog_s     = tog_sync[SYNC_STAGES-1];
  assign inta_fall = inta_d & ~inta_s;
  assign inta_rise = ~inta_d & inta_s;

  logic [2:0] lp, lp_nxt, sel, win, isr_hi;
  logic [7:0] req, irr_nxt, isr_nxt;
  logic       win_vld, isr_vld, pending, spurious;
  logic       int_nxt, flag_nxt, ack1_entry, aeoi_clr;
`ifdef AUTO_ROTATE_EN
  logic       rot_aeoi, rot_nxt;
`endif

  function automatic logic [2:0] slot(input logic [2:0] base, input int r);
    return base + 3'(r) + 3'd1;
  endfunction

  function automatic logic [2:0] rank_of(input logic [2:0] idx, input logic [2:0] base);
    return idx - base - 3'd1;
  endfunction

  assign req = irr & ~IMR;

  // Walk from lowest to highest priority so the last hit is the winner.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    isr_hi  = '0;
    isr_vld = 1'b0;
    for (int r = 7; r >= 0; r--) begin
      if (req[slot(lp, r)]) begin
        win     = slot(lp, r);
        win_vld = 1'b1;
      end
      if (isr[slot(lp, r)]) begin
        isr_hi  = slot(lp, r);
        isr_vld = 1'b1;
      end
    end
  end

  assign pending = win_vld && (!isr_vld || (rank_of(win, lp) < rank_of(isr_hi, lp)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A falling INTA in WAIT1 takes precedence over a request that just went away.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending) state_nxt = WAIT1;
      WAIT1:   if (inta_fall) state_nxt = ACK1;
               else if (!pending) state_nxt = IDLE;
      ACK1:    if (inta_rise) state_nxt = WAIT2;
      WAIT2:   if (inta_fall) state_nxt = ACK2;
      ACK2:    if (inta_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    int_nxt    = pending && (state == IDLE || state == WAIT1);
    flag_nxt   = (state_nxt == ACK2);
    ack1_entry = (state == WAIT1) && inta_fall;
    aeoi_clr   = (state == ACK2) && inta_rise && EOI_mode && !spurious;
  end

  // Update order encodes precedence: EOI, then AEOI, then the ACK1 set (set beats EOI clear).
  always_comb begin
    irr_nxt = (irr | (LTIM ? ir_s : (ir_s & ~ir_d))) & ir_s;
    isr_nxt = isr;
    lp_nxt  = lp;
`ifdef AUTO_ROTATE_EN
    rot_nxt = rot_aeoi;
`endif
    if (tog_s != tog_d) begin
      case (EOI_command)
        3'b001: if (isr_vld) isr_nxt[isr_hi] = 1'b0;
        3'b011: isr_nxt[int_level] = 1'b0;
        3'b101: if (isr_vld) begin
                  isr_nxt[isr_hi] = 1'b0;
                  lp_nxt          = isr_hi;
                end
        3'b111: if (isr_vld) begin
                  isr_nxt[int_level] = 1'b0;
                  lp_nxt             = int_level;
                end
        3'b110: lp_nxt = int_level;
`ifdef AUTO_ROTATE_EN
        3'b100: rot_nxt = 1'b1;
        3'b000: rot_nxt = 1'b0;
`endif
        default: ;
      endcase
    end
    if (aeoi_clr) begin
      isr_nxt[sel] = 1'b0;
`ifdef AUTO_ROTATE_EN
      if (rot_aeoi) lp_nxt = sel;
`endif
    end
    if (ack1_entry && win_vld) begin
      isr_nxt[win] = 1'b1;
      irr_nxt[win] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr      <= '0;
      isr      <= '0;
      lp       <= RESET_LP;
      sel      <= '0;
      spurious <= 1'b0;
      vector   <= '0;
      INT      <= 1'b0;
      int_flag <= 1'b0;
    end else begin
      irr      <= irr_nxt;
      isr      <= isr_nxt;
      lp       <= lp_nxt;
      INT      <= int_nxt;
      int_flag <= flag_nxt;
      if (ack1_entry) begin
        sel      <= win_vld ? win : 3'd7;
        spurious <= !win_vld;
      end
      if (flag_nxt) vector <= {VEC_ADD, sel};
    end
  end

`ifdef AUTO_ROTATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rot_aeoi <= 1'b0;
    else        rot_aeoi <= rot_nxt;
  end
`endif

  assign rd_data = read_mode ? isr : irr;

endmodule

// File: tb/tb_interrupt_control_logic.sv
// Self-checking bench for interrupt_control_logic: directed scenarios plus randomized
// stimulus compared against a transaction-level priority/IRR/ISR model.
module tb_interrupt_control_logic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] IR, IMR;
  logic       INTA_n, LTIM, EOI_mode, EOI_command_updated, read_mode;
  logic [4:0] VEC_ADD;
  logic [2:0] EOI_command, int_level;
  logic       INT, int_flag;
  logic [7:0] vector, rd_data, irr, isr;

  always #5 clk = ~clk;

  interrupt_control_logic dut (
    .clk(clk), .rst_n(rst_n), .IR(IR), .INTA_n(INTA_n), .IMR(IMR), .LTIM(LTIM),
    .EOI_mode(EOI_mode), .VEC_ADD(VEC_ADD), .EOI_command(EOI_command),
    .int_level(int_level), .EOI_command_updated(EOI_command_updated),
    .read_mode(read_mode), .INT(INT), .int_flag(int_flag), .vector(vector),
    .rd_data(rd_data), .irr(irr), .isr(isr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit [7:0] m_irr, m_isr, m_lines, m_imr;
  int       m_lp;
  bit       m_rot;

  function automatic int rank(input int i);
    return (i + 7 - m_lp) % 8;
  endfunction

  function automatic int top(input bit [7:0] v);
    int best = -1;
    for (int i = 0; i < 8; i++)
      if (v[i] && (best < 0 || rank(i) < rank(best))) best = i;
    return best;
  endfunction

  function automatic bit m_pending();
    int w = top(m_irr & ~m_imr);
    int h = top(m_isr);
    if (w < 0) return 1'b0;
    if (h < 0) return 1'b1;
    return rank(w) < rank(h);
  endfunction

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic compare_all();
    check("irr", 32'(irr), 32'(m_irr));
    check("isr", 32'(isr), 32'(m_isr));
    check("INT", 32'(INT), 32'(m_pending()));
    check("int_flag_idle", 32'(int_flag), 32'(0));
    read_mode = 1'b0;
    #1 check("rd_irr", 32'(rd_data), 32'(m_irr));
    read_mode = 1'b1;
    #1 check("rd_isr", 32'(rd_data), 32'(m_isr));
  endtask

  task automatic set_ir(input bit [7:0] nv);
    for (int i = 0; i < 8; i++) begin
      if (LTIM)             m_irr[i] = nv[i];
      else if (!nv[i])      m_irr[i] = 1'b0;
      else if (!m_lines[i]) m_irr[i] = 1'b1;
    end
    m_lines = nv;
    IR = nv;
    settle();
    compare_all();
  endtask

  task automatic set_imr(input bit [7:0] v);
    m_imr = v;
    IMR = v;
    settle();
    compare_all();
  endtask

  task automatic handshake();
    int w = top(m_irr & ~m_imr);
    bit [7:0] exp_vec;
    exp_vec = {VEC_ADD, 3'(w)};
    INTA_n = 1'b0;
    repeat (6) @(negedge clk);
    check("INT_in_ack1", 32'(INT), 32'(0));
    check("flag_in_ack1", 32'(int_flag), 32'(0));
    INTA_n = 1'b1;
    repeat (6) @(negedge clk);
    INTA_n = 1'b0;
    repeat (6) @(negedge clk);
    check("flag_in_ack2", 32'(int_flag), 32'(1));
    check("vector", 32'(vector), 32'(exp_vec));
    INTA_n = 1'b1;
    repeat (6) @(negedge clk);
    m_isr[w] = 1'b1;
    m_irr[w] = LTIM && m_lines[w];
    if (EOI_mode) begin
      m_isr[w] = 1'b0;
`ifdef AUTO_ROTATE_EN
      if (m_rot) m_lp = w;
`endif
    end
    compare_all();
  endtask

  task automatic eoi(input bit [2:0] cmd, input bit [2:0] lvl);
    int h = top(m_isr);
    case (cmd)
      3'b001: if (h >= 0) m_isr[h] = 1'b0;
      3'b011: m_isr[lvl] = 1'b0;
      3'b101: if (h >= 0) begin m_isr[h] = 1'b0; m_lp = h; end
      3'b111: if (m_isr != 0) begin m_isr[lvl] = 1'b0; m_lp = int'(lvl); end
      3'b110: m_lp = int'(lvl);
`ifdef AUTO_ROTATE_EN
      3'b100: m_rot = 1'b1;
      3'b000: m_rot = 1'b0;
`endif
      default: ;
    endcase
    EOI_command = cmd;
    int_level = lvl;
    EOI_command_updated = ~EOI_command_updated;
    settle();
    compare_all();
  endtask

  task automatic model_reset();
    m_irr = '0; m_isr = '0; m_lines = '0; m_lp = 7; m_rot = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; IR = '0; INTA_n = 1'b1; IMR = '0; LTIM = 1'b0; EOI_mode = 1'b0;
    VEC_ADD = 5'h08; EOI_command = '0; int_level = '0; EOI_command_updated = 1'b0;
    read_mode = 1'b0;
    model_reset();
    m_imr = '0;
    repeat (3) @(negedge clk);
    check("rst_irr", 32'(irr), 32'(0));
    check("rst_isr", 32'(isr), 32'(0));
    check("rst_INT", 32'(INT), 32'(0));
    check("rst_flag", 32'(int_flag), 32'(0));
    check("rst_vector", 32'(vector), 32'(0));
    rst_n = 1'b1;
    settle();
    compare_all();

    // Single request on IR3: vector 8'h43
    set_ir(8'h08);
    check("ir3_INT", 32'(INT), 32'(1));
    handshake();
    check("ir3_isr", 32'(isr), 32'(8'h08));
    check("ir3_vector", 32'(vector), 32'(8'h43));
    set_ir(8'h00);
    eoi(3'b001, 3'd0);

    // IR1 and IR5 together: IR1 first, IR5 after non-specific EOI
    set_ir(8'h22);
    handshake();
    check("ir1_first", 32'(vector[2:0]), 32'(1));
    eoi(3'b001, 3'd0);
    handshake();
    check("ir5_second", 32'(vector[2:0]), 32'(5));

    // Nesting with IR5 in service: IR6 blocked, IR2 nests
    set_ir(8'h40);
    check("ir6_blocked", 32'(INT), 32'(0));
    set_ir(8'h44);
    handshake();
    check("nested_isr", 32'(isr), 32'(8'h24));
    eoi(3'b001, 3'd0);
    eoi(3'b011, 3'd5);
    handshake();
    set_ir(8'h00);
    eoi(3'b011, 3'd6);

    // AEOI, then priority set so IR5 outranks IR0
    EOI_mode = 1'b1;
    set_ir(8'h10);
    handshake();
    check("aeoi_isr", 32'(isr), 32'(0));
    set_ir(8'h00);
    eoi(3'b110, 3'd4);
    set_ir(8'h21);
    handshake();
    check("lp4_ir5_first", 32'(vector[2:0]), 32'(5));
    handshake();
    set_ir(8'h00);
    EOI_mode = 1'b0;

    // Spurious: level-triggered IR2 drops one cycle before INTA falls
    LTIM = 1'b1;
    set_ir(8'h04);
    @(negedge clk) IR = 8'h00;
    @(negedge clk) INTA_n = 1'b0;
    repeat (6) @(negedge clk);
    INTA_n = 1'b1;
    repeat (6) @(negedge clk);
    INTA_n = 1'b0;
    repeat (6) @(negedge clk);
    check("spur_vector", 32'(vector), 32'(8'h47));
    INTA_n = 1'b1;
    repeat (6) @(negedge clk);
    m_lines = '0; m_irr = '0;
    compare_all();
    LTIM = 1'b0;

    // Reset asserted during ACK2
    set_ir(8'h02);
    INTA_n = 1'b0; repeat (6) @(negedge clk);
    INTA_n = 1'b1; repeat (6) @(negedge clk);
    INTA_n = 1'b0; repeat (6) @(negedge clk);
    check("pre_rst_flag", 32'(int_flag), 32'(1));
    rst_n = 1'b0;
    #1;
    check("arst_flag", 32'(int_flag), 32'(0));
    check("arst_INT", 32'(INT), 32'(0));
    check("arst_isr", 32'(isr), 32'(0));
    check("arst_irr", 32'(irr), 32'(0));
    IR = '0; INTA_n = 1'b1;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    settle();
    compare_all();
    set_ir(8'h08);
    handshake();
    check("post_rst_vector", 32'(vector), 32'(8'h43));
    set_ir(8'h00);
    eoi(3'b001, 3'd0);

    // Randomized traffic in edge-triggered mode
    for (int n = 0; n < 200; n++) begin
      int a = $urandom_range(0, 9);
      if (a <= 3)
        set_ir(m_lines ^ (8'h01 << $urandom_range(0, 7)));
      else if (a == 4)
        set_imr(8'($urandom) & 8'($urandom));
      else if (a <= 6)
        eoi(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      else if (m_pending()) begin
        EOI_mode = 1'($urandom_range(0, 1));
        handshake();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_control_logic.md
Name: interrupt_control_logic

Overview:
- Downstream consumer of the 8259 read/write logic's decoded control words: IMR, LTIM, AEOI mode, vector base, and OCW2 EOI command with its toggle flag.
- Holds IRR, ISR and the rotating-priority pointer, and resolves priority.
- Drives INT, sequences the two-pulse 8086 INTA handshake and supplies the interrupt vector to the data bus buffer.
- Supplies IRR/ISR read-back data selected by read_mode.

Parameters:
- SYNC_STAGES, 2, flop stages on each asynchronous input: IR[7:0], INTA_n, EOI_command_updated.
- RESET_LP, 3'd7, lowest-priority pointer value after reset (7 gives IR0 highest priority).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IR  input  8  interrupt request lines, asynchronous.
- INTA_n  input  1  CPU interrupt acknowledge, active low, asynchronous.
- IMR  input  8  mask; 1 masks the line.
- LTIM  input  1  1 = level-triggered, 0 = edge-triggered.
- EOI_mode  input  1  1 = AEOI.
- VEC_ADD  input  5  vector bits [7:3].
- EOI_command  input  3  OCW2[7:5].
- int_level  input  3  OCW2[2:0].
- EOI_command_updated  input  1  toggles once per OCW2 write.
- read_mode  input  1  0 = read IRR, 1 = read ISR.
- INT  output  1  interrupt request to CPU.
- int_flag  output  1  high while the vector must be driven onto the bus.
- vector  output  8  {VEC_ADD, level}.
- rd_data  output  8  read_mode ? isr : irr.
- irr  output  8  interrupt request register.
- isr  output  8  in-service register.

Behaviour:
- Reset values:
  - irr, isr, vector: 8'h00.
  - INT, int_flag: 0.
  - Lowest-priority pointer lp: RESET_LP.
  - FSM: IDLE.
  - All sync flops: IR = 0, INTA_n = 1, toggle = 0.
  - Reset is effective immediately, mid-handshake included.
- Synchronisation: ir_s, inta_s and tog_s are the SYNC_STAGES-delayed inputs. Edges are detected against a one-cycle-delayed copy.
- Priority:
  - rank(i) = (i - lp - 1) mod 8; rank 0 is highest.
  - req = irr & ~IMR.
  - win = the req bit with the lowest rank.
  - pending = win exists AND (isr == 0 OR rank(win) < rank of the highest-priority isr bit). This is fully nested: an equal or lower priority request is blocked.
- IRR, per bit:
  - LTIM = 0: set on ir_s rising edge.
  - LTIM = 1: set while ir_s = 1.
  - Cleared when ir_s = 0 or when acknowledged at ACK1.
  - If set and clear occur in the same cycle, clear wins for the acknowledged bit.
- INT is registered: INT <= pending while the FSM is in IDLE or WAIT1; 0 otherwise.
- FSM:
  - IDLE: pending -> WAIT1.
  - WAIT1:
    - inta_s falling edge -> ACK1, latching sel = win, or 7 with spurious = 1 if req is empty.
    - If pending drops before the INTA edge, return to IDLE.
  - ACK1 (first pulse):
    - On entry, isr[sel] <= 1 and irr[sel] <= 0, unless spurious.
    - INT <= 0.
    - inta_s rising edge -> WAIT2.
  - WAIT2: inta_s falling edge -> ACK2.
  - ACK2:
    - vector = {VEC_ADD, sel} and int_flag = 1 while inta_s = 0.
    - inta_s rising edge -> IDLE, int_flag <= 0.
    - If EOI_mode = 1 and not spurious, isr[sel] <= 0 at that edge.
- EOI commands execute once, one cycle after any change of tog_s:
  - 001 non-specific EOI: clear the highest-priority isr bit.
  - 011 specific EOI: clear isr[int_level].
  - 101 rotate on non-specific EOI: clear the highest-priority isr bit h; lp <= h.
  - 111 rotate on specific EOI: clear isr[int_level]; lp <= int_level.
  - 110 set priority: lp <= int_level.
  - 010: no-op.
  - 000 and 100: see Optional Feature.
  - EOI with isr = 0: no change (rotate variants leave lp unchanged).
- Simultaneous events: an EOI clearing bit n in the same cycle as ACK1 setting bit n results in the set winning.
- rd_data is combinational from the current registers.

Optional Feature:
- Macro: AUTO_ROTATE_EN.
- Defined:
  - Command 100 sets the internal flag rot_aeoi; command 000 clears it. rot_aeoi resets to 0.
  - When rot_aeoi = 1 and EOI_mode = 1, the AEOI clear at the end of ACK2 also sets lp <= sel.
- Undefined:
  - 100 and 000 are no-ops.
  - lp changes only via 101, 111 and 110.

Test Plan:
- Reset; IMR = 0, LTIM = 0, VEC_ADD = 5'h08; pulse IR3 high -> INT = 1; two INTA pulses -> isr = 8'h08, irr = 0, vector = 8'h43 with int_flag = 1 only during the second pulse, INT = 0.
- IR1 and IR5 raised together -> IR1 serviced first. Issue EOI 001 -> isr = 0, INT reasserts, second handshake gives vector level 5.
- isr = 8'h20 (IR5 in service); raise IR6 -> INT stays 0. Raise IR2 -> INT = 1, nested handshake gives isr = 8'h24.
- EOI_mode = 1, IR4 acknowledged -> isr = 0 after the second INTA rising edge. Command 110 with int_level = 4 -> IR5 becomes highest priority over IR0 when both are requested.
- Raise IR2 and drop it after INT but before the first INTA, with LTIM = 1 -> vector level 7, isr unchanged.
- Assert rst_n = 0 during ACK2 -> int_flag, INT, isr and irr go to 0 immediately and the FSM returns to IDLE.
